seq_detector_prog: RTL and testbench

//  Runtime-programmable serial bit-pattern detector; successor to the fixed 1101 FSM detector.

---
 rtl/seq_det_pkg.sv | 21 ++
 rtl/seq_detector_prog_sat_counter.sv | 45 ++++
 rtl/seq_detector_prog.sv | 124 ++++++++++++
 tb/tb_seq_detector_prog.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/seq_det_pkg.sv
// Shared defaults and helpers for the programmable serial pattern detector.
// The mask helper covers patterns up to MASK_W bits; callers truncate to their width.
package seq_det_pkg;

    localparam int          DEF_PAT_W = 16;
    localparam int          DEF_CNT_W = 8;
    localparam logic [15:0] DEF_PAT   = 16'h000D;
    localparam int          DEF_LEN   = 4;
    localparam logic        DEF_OVL   = 1'b1;
    localparam int          MASK_W    = 64;

    function automatic logic [MASK_W-1:0] len_to_mask(input int unsigned len);
        logic [MASK_W-1:0] m;
        m = '0;
        for (int unsigned i = 0; i < MASK_W; i++) begin
            m[i] = (i < len) ? 1'b1 : 1'b0;
        end
        return m;
    endfunction

endpackage

// File: rtl/seq_detector_prog_sat_counter.sv
// Saturating up-counter; a clear in the same cycle as an increment yields 1.
module sat_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] base_s;

    // Next count: clear first, then a saturating increment.
    always_comb begin
        base_s = cnt_q;
        cnt_d  = cnt_q;
        if (clr) begin
            base_s = '0;
        end else begin
            base_s = cnt_q;
        end
        if (inc && (base_s != CNT_MAX)) begin
            cnt_d = base_s + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_d = base_s;
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/seq_detector_prog.sv
// Runtime-programmable serial bit-pattern detector with overlap control and a
// saturating match counter. Pattern is right-aligned, last received bit in bit 0.
module seq_detector_prog #(
    parameter int               PAT_W   = seq_det_pkg::DEF_PAT_W,
    parameter int               CNT_W   = seq_det_pkg::DEF_CNT_W,
    parameter logic [PAT_W-1:0] DEF_PAT = PAT_W'(seq_det_pkg::DEF_PAT),
    parameter int               DEF_LEN = seq_det_pkg::DEF_LEN,
    parameter logic             DEF_OVL = seq_det_pkg::DEF_OVL,
    localparam int              LEN_W   = $clog2(PAT_W + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             in_bit,
    input  logic             cfg_load,
    input  logic [PAT_W-1:0] cfg_pattern,
    input  logic [LEN_W-1:0] cfg_len,
    input  logic             cfg_overlap,
    input  logic             count_clr,
    output logic             detect,
    output logic [CNT_W-1:0] match_count,
    output logic             cfg_err
);

    import seq_det_pkg::*;

    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(PAT_W);
    localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

    logic [PAT_W-1:0] pat_q,  pat_d;
    logic [LEN_W-1:0] len_q,  len_d;
    logic             ovl_q,  ovl_d;
    logic [PAT_W-1:0] hist_q, hist_d;
    logic [LEN_W-1:0] fill_q, fill_d;
    logic             detect_q, detect_d;
    logic             cfg_err_q, cfg_err_d;

    logic [PAT_W-1:0] hist_shift_s;
    logic [LEN_W-1:0] fill_inc_s;
    logic [PAT_W-1:0] mask_s;
    logic             cfg_ok_s;
    logic             match_s;

    // Candidate history/fill for a sampled bit and the masked pattern compare.
    always_comb begin
        hist_shift_s = {hist_q[PAT_W-2:0], in_bit};
        if (fill_q == LEN_MAX) begin
            fill_inc_s = fill_q;
        end else begin
            fill_inc_s = fill_q + LEN_ONE;
        end
        mask_s   = PAT_W'(len_to_mask(32'(len_q)));
        cfg_ok_s = (cfg_len != '0) && (cfg_len <= LEN_MAX);
        match_s  = in_valid && !cfg_load && (fill_inc_s >= len_q) &&
                   ((hist_shift_s & mask_s) == (pat_q & mask_s));
    end

    // Config, history and output-pulse next state; a config load always flushes history.
    always_comb begin
        pat_d     = pat_q;
        len_d     = len_q;
        ovl_d     = ovl_q;
        hist_d    = hist_q;
        fill_d    = fill_q;
        cfg_err_d = 1'b0;
        detect_d  = match_s;
        if (cfg_load) begin
            hist_d = '0;
            fill_d = '0;
            if (cfg_ok_s) begin
                pat_d = cfg_pattern;
                len_d = cfg_len;
                ovl_d = cfg_overlap;
            end else begin
                cfg_err_d = 1'b1;
            end
        end else if (in_valid) begin
            hist_d = hist_shift_s;
            if (match_s && !ovl_q) begin
                fill_d = '0;
            end else begin
                fill_d = fill_inc_s;
            end
        end else begin
            hist_d = hist_q;
            fill_d = fill_q;
        end
    end

    // State registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            pat_q     <= DEF_PAT;
            len_q     <= LEN_W'(DEF_LEN);
            ovl_q     <= DEF_OVL;
            hist_q    <= '0;
            fill_q    <= '0;
            detect_q  <= 1'b0;
            cfg_err_q <= 1'b0;
        end else begin
            pat_q     <= pat_d;
            len_q     <= len_d;
            ovl_q     <= ovl_d;
            hist_q    <= hist_d;
            fill_q    <= fill_d;
            detect_q  <= detect_d;
            cfg_err_q <= cfg_err_d;
        end
    end

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_cnt (
        .clk (clk),
        .rst (rst),
        .inc (match_s),
        .clr (count_clr),
        .cnt (match_count)
    );

    assign detect  = detect_q;
    assign cfg_err = cfg_err_q;

endmodule

// File: tb/tb_seq_detector_prog.sv
// Directed self-checking bench for seq_detector_prog; a second instance with a
// 2-bit counter shares all stimulus to exercise counter saturation.
module tb_seq_detector_prog;

    localparam int PAT_W = 16;
    localparam int LEN_W = $clog2(PAT_W + 1);

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_bit;
    logic             cfg_load;
    logic [PAT_W-1:0] cfg_pattern;
    logic [LEN_W-1:0] cfg_len;
    logic             cfg_overlap;
    logic             count_clr;
    logic             detect_a, cfg_err_a;
    logic [7:0]       count_a;
    logic             detect_b, cfg_err_b;
    logic [1:0]       count_b;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    seq_detector_prog dut_a (
        .clk (clk), .rst (rst), .in_valid (in_valid), .in_bit (in_bit),
        .cfg_load (cfg_load), .cfg_pattern (cfg_pattern), .cfg_len (cfg_len),
        .cfg_overlap (cfg_overlap), .count_clr (count_clr),
        .detect (detect_a), .match_count (count_a), .cfg_err (cfg_err_a)
    );

    seq_detector_prog #(.CNT_W (2)) dut_b (
        .clk (clk), .rst (rst), .in_valid (in_valid), .in_bit (in_bit),
        .cfg_load (cfg_load), .cfg_pattern (cfg_pattern), .cfg_len (cfg_len),
        .cfg_overlap (cfg_overlap), .count_clr (count_clr),
        .detect (detect_b), .match_count (count_b), .cfg_err (cfg_err_b)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic b, input logic exp_det, input string tag);
        in_valid = 1'b1;
        in_bit   = b;
        tick();
        in_valid = 1'b0;
        chk(tag, 32'(detect_a), 32'(exp_det));
    endtask

    task automatic send_seq(input logic [31:0] bits, input logic [31:0] exp,
                            input int n, input string tag);
        for (int i = n - 1; i >= 0; i--) begin
            send(bits[i], exp[i], $sformatf("%s_b%0d", tag, n - i));
        end
    endtask

    task automatic gap(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            tick();
            chk($sformatf("%s_gap%0d", tag, i), 32'(detect_a), 32'd0);
        end
    endtask

    task automatic load(input logic [PAT_W-1:0] pat, input logic [LEN_W-1:0] len,
                        input logic ovl, input logic clr);
        cfg_load    = 1'b1;
        cfg_pattern = pat;
        cfg_len     = len;
        cfg_overlap = ovl;
        count_clr   = clr;
        tick();
        cfg_load  = 1'b0;
        count_clr = 1'b0;
    endtask

    logic [15:0] a5;

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_bit = 1'b0; cfg_load = 1'b0;
        cfg_pattern = '0; cfg_len = '0; cfg_overlap = 1'b0; count_clr = 1'b0;
        tick(); tick();
        rst = 1'b0;
        chk("rst_detect", 32'(detect_a), 32'd0);
        chk("rst_count", 32'(count_a), 32'd0);
        chk("rst_cfg_err", 32'(cfg_err_a), 32'd0);

        // 1: default 1101, overlapping
        send_seq(32'b1101101, 32'b0001001, 7, "t1");
        chk("t1_count", 32'(count_a), 32'd2);

        // 2: non-overlapping 1101
        load(16'h000D, 5'd4, 1'b0, 1'b1);
        chk("t2_load_err", 32'(cfg_err_a), 32'd0);
        chk("t2_clr_count", 32'(count_a), 32'd0);
        send_seq(32'b1101101, 32'b0001000, 7, "t2");
        chk("t2_count", 32'(count_a), 32'd1);

        // 3: full-width pattern, without then with gaps
        a5 = 16'hA5A5;
        load(16'hA5A5, 5'd16, 1'b1, 1'b1);
        send_seq({16'd0, a5}, 32'h0000_0001, 16, "t3a");
        load(16'hA5A5, 5'd16, 1'b1, 1'b0);
        send_seq({24'd0, a5[15:8]}, 32'd0, 8, "t3g1");
        gap(3, "t3");
        send_seq({28'd0, a5[7:4]}, 32'd0, 4, "t3g2");
        gap(2, "t3");
        send_seq({28'd0, a5[3:0]}, 32'h1, 4, "t3g3");
        chk("t3_count", 32'(count_a), 32'd2);

        // 4: illegal lengths rejected, old config kept
        load(16'h000D, 5'd4, 1'b1, 1'b1);
        load(16'hFFFF, 5'd0, 1'b0, 1'b0);
        chk("t4_err_len0", 32'(cfg_err_a), 32'd1);
        tick();
        chk("t4_err_pulse0", 32'(cfg_err_a), 32'd0);
        load(16'hFFFF, 5'd17, 1'b0, 1'b0);
        chk("t4_err_len17", 32'(cfg_err_a), 32'd1);
        tick();
        chk("t4_err_pulse17", 32'(cfg_err_a), 32'd0);
        send_seq(32'b1101101, 32'b0001001, 7, "t4");

        // 5: saturation on the 2-bit instance, clear-with-match
        load(16'h000D, 5'd4, 1'b1, 1'b1);
        send_seq(32'b1101101101101101, 32'b0001001001001001, 16, "t5");
        chk("t5_count_a", 32'(count_a), 32'd5);
        chk("t5_count_b_sat", 32'(count_b), 32'd3);
        send(1'b1, 1'b0, "t5_c1");
        send(1'b0, 1'b0, "t5_c2");
        count_clr = 1'b1;
        send(1'b1, 1'b1, "t5_c3");
        count_clr = 1'b0;
        chk("t5_clr_match_a", 32'(count_a), 32'd1);
        chk("t5_clr_match_b", 32'(count_b), 32'd1);

        // 6: reset mid-stream suppresses completing bit
        send_seq(32'b110, 32'b000, 3, "t6a");
        rst = 1'b1; in_valid = 1'b1; in_bit = 1'b1;
        tick();
        rst = 1'b0; in_valid = 1'b0;
        chk("t6_rst_detect", 32'(detect_a), 32'd0);
        chk("t6_rst_count", 32'(count_a), 32'd0);
        chk("t6_rst_cfg_err", 32'(cfg_err_a), 32'd0);
        send(1'b1, 1'b0, "t6_after_rst");

        // cfg_load with a completing bit discards it and flushes history
        send_seq(32'b110, 32'b000, 3, "t6b");
        in_valid = 1'b1; in_bit = 1'b1;
        load(16'h000D, 5'd4, 1'b1, 1'b0);
        in_valid = 1'b0;
        chk("t6_load_no_detect", 32'(detect_a), 32'd0);
        send_seq(32'b1101, 32'b0001, 4, "t6c");

        // length-1 pattern, non-overlapping
        load(16'hFFFE | 16'h0001, 5'd1, 1'b0, 1'b1);
        send_seq(32'b10110, 32'b10110, 5, "t7");
        chk("t7_count", 32'(count_a), 32'd3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
